// File: rtl/ram1_arbiter.sv
// Shares the single-port RAM1 SRAM between instruction fetch and the MEM stage (MEM has priority).
// Latency: read ack WAIT_CYCLES+2 cycles after the request is seen in IDLE; write ack WAIT_CYCLES+4.
// Backpressure: requests are level-held until ack; stall_req stays high while a request is pending and unacked.
module ram1_arbiter #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_ack,
   output logic [31:0] mem_rdata,
   output logic        stall_req,
   output logic [19:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        ram_data_oe,
   output logic        ram_ce_n,
   output logic        ram_oe_n,
   output logic        ram_we_n
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_RD       = 3'd1;
   localparam logic [2:0] S_WR_SETUP = 3'd2;
   localparam logic [2:0] S_WR_PULSE = 3'd3;
   localparam logic [2:0] S_WR_HOLD  = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   // Reload value for the read and write-pulse phases; the phase ends when the counter reaches zero.
   localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

   logic [2:0] state;
   logic [2:0] cnt;
   logic       owner_mem;

   // Only the low 20 address bits reach the SRAM; the upper bits are intentionally dropped.
   logic       unused_addr_hi;
   assign unused_addr_hi = ^{if_addr[31:20], mem_addr[31:20]};

   // Sequencer: grant in IDLE, step through the strobe phases, latch address/data at grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         owner_mem <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (mem_req) begin
                  owner_mem <= 1'b1;
                  ram_addr  <= mem_addr[19:0];
                  ram_wdata <= mem_wdata;
                  cnt       <= WAIT_LD;
                  state     <= mem_we ? S_WR_SETUP : S_RD;
               end else if (if_req) begin
                  owner_mem <= 1'b0;
                  ram_addr  <= if_addr[19:0];
                  cnt       <= WAIT_LD;
                  state     <= S_RD;
               end
            end
            S_RD: begin
               if (cnt == 3'd0) state <= S_DONE;
               else             cnt   <= cnt - 3'd1;
            end
            S_WR_SETUP: begin
               cnt   <= WAIT_LD;
               state <= S_WR_PULSE;
            end
            S_WR_PULSE: begin
               if (cnt == 3'd0) state <= S_WR_HOLD;
               else             cnt   <= cnt - 3'd1;
            end
            S_WR_HOLD: state <= S_DONE;
            S_DONE:    state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

   // Capture SRAM data on the last read cycle into the owning requester's register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_rdata  <= '0;
         mem_rdata <= '0;
      end else if (state == S_RD && cnt == 3'd0) begin
         if (owner_mem) mem_rdata <= ram_rdata;
         else           if_rdata  <= ram_rdata;
      end
   end

   // Strobes decode directly from state so an asynchronous reset releases them at once.
   always_comb begin
      ram_ce_n    = 1'b1;
      ram_oe_n    = 1'b1;
      ram_we_n    = 1'b1;
      ram_data_oe = 1'b0;
      case (state)
         S_RD: begin
            ram_ce_n = 1'b0;
            ram_oe_n = 1'b0;
         end
         S_WR_SETUP, S_WR_HOLD: begin
            ram_ce_n    = 1'b0;
            ram_data_oe = 1'b1;
         end
         S_WR_PULSE: begin
            ram_ce_n    = 1'b0;
            ram_we_n    = 1'b0;
            ram_data_oe = 1'b1;
         end
         default: ;
      endcase
   end

   assign if_ack    = (state == S_DONE) && !owner_mem;
   assign mem_ack   = (state == S_DONE) &&  owner_mem;
   assign stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

// File: tb/tb_ram1_arbiter.sv
// Bench for ram1_arbiter: transaction-timeline reference model checked every cycle,
// directed literal checks for the documented latencies, plus a WAIT_CYCLES=0 instance.
module tb_ram1_arbiter;

   localparam int W = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
   logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
   logic        if_ack, mem_ack, stall_req, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;
   logic [31:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
   logic [19:0] ram_addr;

   // second instance with zero wait states
   logic        mem_req0 = 1'b0, mem_we0 = 1'b0;
   logic [31:0] mem_addr0 = '0, mem_wdata0 = '0;
   logic        if_ack0, mem_ack0, stall_req0, ram_data_oe0, ram_ce_n0, ram_oe_n0, ram_we_n0;
   logic [31:0] if_rdata0, mem_rdata0, ram_wdata0, ram_rdata0;
   logic [19:0] ram_addr0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ram1_arbiter #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_req(stall_req),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .ram_data_oe(ram_data_oe), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
   );

   ram1_arbiter #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst),
      .if_req(1'b0), .if_addr(32'h0), .if_ack(if_ack0), .if_rdata(if_rdata0),
      .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_ack(mem_ack0), .mem_rdata(mem_rdata0), .stall_req(stall_req0),
      .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0),
      .ram_data_oe(ram_data_oe0), .ram_ce_n(ram_ce_n0), .ram_oe_n(ram_oe_n0), .ram_we_n(ram_we_n0)
   );

   assign ram_rdata0 = !ram_oe_n0 ? 32'h12345678 : 32'hFFFF0000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   // Unwritten SRAM locations hold an address-derived pattern.
   function automatic logic [31:0] init_val(input logic [19:0] a);
      return {a[11:0], a} ^ 32'h5A5A0000;
   endfunction

   // ---------------- SRAM environment ----------------
   logic [31:0] sram [bit [19:0]];

   always @(negedge clk)
      ram_rdata = (!ram_ce_n && !ram_oe_n) ?
                  (sram.exists(ram_addr) ? sram[ram_addr] : init_val(ram_addr)) : 32'h0BAD0BAD;

   always @(posedge clk)
      if (rst && !ram_ce_n && !ram_we_n) sram[ram_addr] = ram_wdata;

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [bit [19:0]];

   function automatic logic [31:0] ref_rd(input logic [19:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   int          cyc = 0;
   bit          m_busy = 1'b0, m_mem = 1'b0, m_wr = 1'b0;
   int          m_grant = 0, k = 0, done_k = 0;
   logic [19:0] m_addr = '0;
   logic [31:0] m_wdata = '0, m_rdata = '0, e_if_rd = '0, e_mem_rd = '0;
   logic        e_ce, e_oe, e_we, e_doe, e_ifa, e_mema, c_addr, c_wd;

   // One access at a time: its cycle offset from the grant decides every output.
   always @(negedge clk) begin
      if (!rst) begin
         m_busy   = 1'b0;
         e_if_rd  = '0;
         e_mem_rd = '0;
         chk("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, 4'b1110);
         chk("rst_acks", {if_ack, mem_ack}, 2'b00);
         chk("rst_ram_addr", ram_addr, 20'h0);
         chk("rst_ram_wdata", ram_wdata, 32'h0);
         chk("rst_rdata", {if_rdata, mem_rdata}, 64'h0);
      end else begin
         e_ce = 1; e_oe = 1; e_we = 1; e_doe = 0; e_ifa = 0; e_mema = 0; c_addr = 0; c_wd = 0;
         if (m_busy) begin
            k      = cyc - m_grant;
            done_k = m_wr ? W + 4 : W + 2;
            if (k == done_k) begin
               if (m_mem) e_mema = 1; else e_ifa = 1;
               if (m_wr) ref_mem[m_addr] = m_wdata;
               else if (m_mem) e_mem_rd = m_rdata;
               else e_if_rd = m_rdata;
            end else if (!m_wr) begin
               e_ce = 0; e_oe = 0; c_addr = 1;
            end else begin
               e_ce = 0; e_doe = 1; c_addr = 1; c_wd = 1;
               e_we = !(k >= 2 && k <= W + 2);
            end
         end
         chk("strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe}, {e_ce, e_oe, e_we, e_doe});
         chk("if_ack", if_ack, e_ifa);
         chk("mem_ack", mem_ack, e_mema);
         chk("if_rdata", if_rdata, e_if_rd);
         chk("mem_rdata", mem_rdata, e_mem_rd);
         chk("stall_req", stall_req, (if_req & ~e_ifa) | (mem_req & ~e_mema));
         if (c_addr) chk("ram_addr", ram_addr, m_addr);
         if (c_wd) chk("ram_wdata", ram_wdata, m_wdata);
         if (m_busy && k == done_k) m_busy = 1'b0;
         else if (!m_busy) begin
            if (mem_req) begin
               m_busy = 1; m_mem = 1; m_wr = mem_we; m_addr = mem_addr[19:0]; m_wdata = mem_wdata;
            end else if (if_req) begin
               m_busy = 1; m_mem = 0; m_wr = 0; m_addr = if_addr[19:0];
            end
            if (m_busy) begin
               m_grant = cyc;
               m_rdata = ref_rd(m_addr);
            end
         end
      end
      cyc++;
   end

   // previous-cycle acks for the random requesters
   logic seen_if_ack = 1'b0, seen_mem_ack = 1'b0;
   always @(negedge clk) begin
      seen_if_ack  <= if_ack;
      seen_mem_ack <= mem_ack;
   end

   // ---------------- directed helpers ----------------
   int          if_ack_cyc, mem_ack_cyc, oe_first, oe_last, we_cnt, doe_first, doe_last, stall_gap;
   logic [19:0] addr_seen;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge with requests already driven (that cycle is cycle 0).
   task automatic run(input int max, input int drop_if_at);
      bit p_if, p_mem;
      p_if = if_req; p_mem = mem_req;
      if_ack_cyc = -1; mem_ack_cyc = -1; oe_first = -1; oe_last = -1;
      we_cnt = 0; doe_first = -1; doe_last = -1; stall_gap = 0; addr_seen = '0;
      for (int c = 0; c < max; c++) begin
         @(negedge clk);
         if (!ram_oe_n) begin if (oe_first < 0) oe_first = c; oe_last = c; end
         if (!ram_we_n) we_cnt++;
         if (ram_data_oe) begin if (doe_first < 0) doe_first = c; doe_last = c; end
         if (c == 1) addr_seen = ram_addr;
         if (if_ack && p_if) begin if_ack_cyc = c; p_if = 0; end
         if (mem_ack && p_mem) begin mem_ack_cyc = c; p_mem = 0; end
         if (!stall_req && ((p_if && if_req) || (p_mem && mem_req))) stall_gap++;
         tick();
         if (!p_if || c == drop_if_at) if_req = 1'b0;
         if (!p_mem) mem_req = 1'b0;
         if (!p_if && !p_mem) break;
      end
   endtask

   task automatic w0_run(input bit we, output int ack_c, output int wcnt);
      mem_we0 = we; mem_req0 = 1'b1; mem_addr0 = 32'h30; mem_wdata0 = 32'h55AA55AA;
      ack_c = -1; wcnt = 0;
      for (int c = 0; c < 12 && ack_c < 0; c++) begin
         @(negedge clk);
         if (!ram_we_n0) wcnt++;
         if (mem_ack0) ack_c = c;
      end
      tick();
      mem_req0 = 1'b0;
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = $urandom;
      a[19:0] = ($urandom_range(0, 8) == 8) ? 20'hFFFFF : 20'($urandom_range(0, 7));
      return a;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int a0, w0, acks;
      sram[20'h00010]    = 32'h3C010001;
      ref_mem[20'h00010] = 32'h3C010001;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b111);
      chk("reset_acks", {if_ack, mem_ack}, 2'b00);
      chk("reset_if_rdata", if_rdata, 32'h0);
      tick();
      rst = 1'b1;
      tick();

      // IF read with a known SRAM word
      if_req = 1'b1; if_addr = 32'h00000010;
      run(20, -1);
      chk("if_rd_ack_cycle", if_ack_cyc, 3);
      chk("if_rd_data", if_rdata, 32'h3C010001);
      chk("if_rd_oe_first", oe_first, 1);
      chk("if_rd_oe_last", oe_last, 2);
      chk("if_rd_stall_gap", stall_gap, 0);

      // MEM write then read back
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h00000020; mem_wdata = 32'hDEADBEEF;
      run(20, -1);
      chk("wr_we_cycles", we_cnt, 2);
      chk("wr_doe_first", doe_first, 1);
      chk("wr_doe_last", doe_last, 4);
      chk("wr_ack_cycle", mem_ack_cyc, 5);
      chk("model_mem_20", ref_rd(20'h00020), 32'hDEADBEEF);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h00000020;
      run(20, -1);
      chk("rdback_ack_cycle", mem_ack_cyc, 3);
      chk("rdback_data", mem_rdata, 32'hDEADBEEF);

      // simultaneous requests: MEM first, IF afterwards
      if_req = 1'b1; if_addr = 32'h00000040;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h00000004;
      run(30, -1);
      chk("sim_mem_ack_cycle", mem_ack_cyc, 3);
      chk("sim_if_ack_cycle", if_ack_cyc, 7);
      chk("sim_stall_gap", stall_gap, 0);
      chk("sim_if_data", if_rdata, init_val(20'h00040));

      // top address truncates to 20 bits
      if_req = 1'b1; if_addr = 32'hFFFFFFFF;
      run(20, -1);
      chk("top_addr", addr_seen, 20'hFFFFF);
      chk("top_ack_cycle", if_ack_cyc, 3);

      // requester drops mid-access; ack still pulses
      if_req = 1'b1; if_addr = 32'h00000010;
      run(20, 1);
      chk("drop_ack_cycle", if_ack_cyc, 3);

      // zero wait states
      w0_run(1'b0, a0, w0);
      chk("w0_rd_ack_cycle", a0, 2);
      chk("w0_rd_data", mem_rdata0, 32'h12345678);
      w0_run(1'b1, a0, w0);
      chk("w0_wr_ack_cycle", a0, 4);
      chk("w0_wr_we_cycles", w0, 1);

      // asynchronous reset in the middle of the write pulse
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h00000050; mem_wdata = 32'h01020304;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("abort_we_before", ram_we_n, 1'b0);
      rst = 1'b0;
      mem_req = 1'b0;
      #1;
      chk("abort_we_async", ram_we_n, 1'b1);
      chk("abort_ce_async", ram_ce_n, 1'b1);
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (mem_ack) acks++;
      end
      chk("abort_no_ack", acks, 0);
      tick();
      rst = 1'b1;
      tick();

      // randomized traffic, checked cycle by cycle by the model
      for (int c = 0; c < 3000; c++) begin
         if (seen_if_ack || !if_req) begin
            if_req  = ($urandom_range(0, 2) != 0);
            if_addr = rnd_addr();
         end else if ($urandom_range(0, 63) == 0) if_req = 1'b0;
         if (seen_mem_ack || !mem_req) begin
            mem_req   = ($urandom_range(0, 2) == 0);
            mem_we    = $urandom_range(0, 1);
            mem_addr  = rnd_addr();
            mem_wdata = $urandom;
         end else if ($urandom_range(0, 63) == 0) mem_req = 1'b0;
         tick();
      end
      if_req = 1'b0; mem_req = 1'b0;
      repeat (10) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
